// File: rtl/cache_req_arbiter_if.sv
// Requester, response and cache_core signals of cache_req_arbiter.
// Defining ARB_STATS_EN adds the grant_cnt/conflict_cnt statistics outputs.
interface cache_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_hit;
  logic [ADDR_W-1:0]         cache_address;
  logic [DATA_W-1:0]         cache_data_in;
  logic                      cache_read_en;
  logic                      cache_write_en;
  logic [DATA_W-1:0]         cache_data_out;
  logic                      cache_hit_flag;
  logic                      busy;
  logic [2:0]                grant_id;
`ifdef ARB_STATS_EN
  logic [NUM_REQ*CNT_W-1:0]  grant_cnt;
  logic [CNT_W-1:0]          conflict_cnt;
`endif

  modport master (
    output req_valid, req_write, req_addr, req_wdata, cache_data_out, cache_hit_flag,
    input  req_ready, rsp_valid, rsp_rdata, rsp_hit, cache_address, cache_data_in,
    input  cache_read_en, cache_write_en, busy, grant_id
`ifdef ARB_STATS_EN
    , input grant_cnt, conflict_cnt
`endif
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, cache_data_out, cache_hit_flag,
    output req_ready, rsp_valid, rsp_rdata, rsp_hit, cache_address, cache_data_in,
    output cache_read_en, cache_write_en, busy, grant_id
`ifdef ARB_STATS_EN
    , output grant_cnt, conflict_cnt
`endif
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache_core port among NUM_REQ requesters.
// Optional ARB_STATS_EN macro adds saturating grant and conflict counters.
module cache_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CACHE_LAT = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  cache_req_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam int LAT_W = (CACHE_LAT > 1) ? $clog2(CACHE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CACHE_LAT - 1);

  logic [1:0]         state_r;
  logic [2:0]         rr_ptr_r;
  logic [2:0]         grant_id_r;
  logic [LAT_W-1:0]   lat_cnt_r;
  logic               write_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [DATA_W-1:0]  rsp_rdata_r;
  logic               rsp_hit_r;
  logic               read_en_r;
  logic               write_en_r;
  logic               busy_r;
  logic [NUM_REQ-1:0] req_ready_r;
  logic [NUM_REQ-1:0] rsp_valid_r;

  logic [7:0]         valid_ext_s;
  logic [7:0]         write_ext_s;
  logic [ADDR_W-1:0]  addr_a_s [8];
  logic [DATA_W-1:0]  wdata_a_s [8];
  logic [2:0]         pick_s;
  logic               any_req_s;

  // First valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 3'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [2:0] id);
    for (int i = 0; i < NUM_REQ; i++) one_hot[i] = (id == 3'(i));
  endfunction

  // Unpack the requester buses and choose the round-robin winner.
  always_comb begin
    valid_ext_s = 8'd0;
    write_ext_s = 8'd0;
    for (int i = 0; i < 8; i++) begin
      addr_a_s[i]  = {ADDR_W{1'b0}};
      wdata_a_s[i] = {DATA_W{1'b0}};
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_ext_s[i] = bus.req_valid[i];
      write_ext_s[i] = bus.req_write[i];
      addr_a_s[i]    = bus.req_addr[i*ADDR_W +: ADDR_W];
      wdata_a_s[i]   = bus.req_wdata[i*DATA_W +: DATA_W];
    end
    any_req_s = |bus.req_valid;
    pick_s    = rr_pick(valid_ext_s, rr_ptr_r);
  end

  // Transaction FSM; pulse outputs default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 3'd0;
      grant_id_r  <= 3'd0;
      lat_cnt_r   <= {LAT_W{1'b0}};
      write_r     <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_hit_r   <= 1'b0;
      read_en_r   <= 1'b0;
      write_en_r  <= 1'b0;
      busy_r      <= 1'b0;
      req_ready_r <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
    end else begin
      req_ready_r <= {NUM_REQ{1'b0}};
      rsp_valid_r <= {NUM_REQ{1'b0}};
      read_en_r   <= 1'b0;
      write_en_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_id_r  <= pick_s;
            write_r     <= write_ext_s[pick_s];
            addr_r      <= addr_a_s[pick_s];
            wdata_r     <= wdata_a_s[pick_s];
            req_ready_r <= one_hot(pick_s);
            read_en_r   <= ~write_ext_s[pick_s];
            write_en_r  <= write_ext_s[pick_s];
            busy_r      <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          lat_cnt_r <= LAT_LOAD;
          state_r   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            rsp_rdata_r <= write_r ? {DATA_W{1'b0}} : bus.cache_data_out;
            rsp_hit_r   <= bus.cache_hit_flag;
            rsp_valid_r <= one_hot(grant_id_r);
            state_r     <= RESP;
          end else begin
            lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          end
        end
        RESP: begin
          rr_ptr_r <= (grant_id_r == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_r + 3'd1;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_r;
  assign bus.rsp_valid      = rsp_valid_r;
  assign bus.rsp_rdata      = rsp_rdata_r;
  assign bus.rsp_hit        = rsp_hit_r;
  assign bus.cache_address  = addr_r;
  assign bus.cache_data_in  = wdata_r;
  assign bus.cache_read_en  = read_en_r;
  assign bus.cache_write_en = write_en_r;
  assign bus.busy           = busy_r;
  assign bus.grant_id       = grant_id_r;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_r [NUM_REQ];
  logic [CNT_W-1:0] conflict_cnt_r;
  logic             multi_req_s;

  assign multi_req_s = |(bus.req_valid & (bus.req_valid - NUM_REQ'(1)));

  // Saturating statistics, stepped on every IDLE->ISSUE grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_r[i] <= {CNT_W{1'b0}};
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == IDLE && any_req_s) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick_s == 3'(i) && grant_cnt_r[i] != {CNT_W{1'b1}}) begin
          grant_cnt_r[i] <= grant_cnt_r[i] + CNT_W'(1);
        end
      end
      if (multi_req_s && conflict_cnt_r != {CNT_W{1'b1}}) begin
        conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign bus.grant_cnt[g*CNT_W +: CNT_W] = grant_cnt_r[g];
  end
  assign bus.conflict_cnt = conflict_cnt_r;
`endif

endmodule
